// File: rtl/negacyclic_polymul.sv
// Streaming schoolbook polynomial multiplier over Z_Q[x]/(x^N+1), or x^N-1 when mode_neg=0.
// Ports:
//   clk, a_rst_n           clock (rising edge), asynchronous active-low reset
//   p_vld/p_rdy/p_data/p_last  residue coefficient stream, joint handshake with u
//   u_vld/u_rdy/u_data/u_last  small signed coefficient stream
//   mode_neg               1 = negacyclic, 0 = cyclic, sampled on beat 0
//   z_vld/z_rdy/z_data/z_last  result stream with full backpressure
//   err                    one-cycle pulse after a beat with a protocol error
//   busy                   high while computing or draining
module negacyclic_polymul #(
    parameter int unsigned N  = 8,
    parameter int unsigned QW = 14,
    parameter int unsigned Q  = 12289,
    parameter int unsigned UW = 2
) (
    input  logic          clk,
    input  logic          a_rst_n,
    input  logic          p_vld,
    output logic          p_rdy,
    input  logic [QW-1:0] p_data,
    input  logic          p_last,
    input  logic          u_vld,
    output logic          u_rdy,
    input  logic [UW-1:0] u_data,
    input  logic          u_last,
    input  logic          mode_neg,
    output logic          z_vld,
    input  logic          z_rdy,
    output logic [QW-1:0] z_data,
    output logic          z_last,
    output logic          err,
    output logic          busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = 2 * QW;
    localparam logic [PW-1:0] Q_P = PW'(Q);
    localparam logic [QW:0]   Q_E = (QW + 1)'(Q);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] j_q, k_q, d_q;
    logic          mode_q;
    logic [QW-1:0] p_mem [N];
    logic [QW-1:0] u_mem [N];
    logic [QW-1:0] acc   [N];
    logic          rdy_q, z_vld_q, z_last_q, err_q, busy_q;
    logic [QW-1:0] z_data_q;

    logic          beat_c, last_any_c, load_end_c, proto_err_c;
    logic          drain_adv_c, drain_done_c;
    logic [QW:0]   u_sx_c;
    logic [QW-1:0] u_res_c;
    logic [IW-1:0] u_idx_c   [N];
    logic [PW-1:0] prod_c    [N];
    logic [QW-1:0] red_c     [N];
    logic [QW:0]   tmp_c     [N];
    logic [QW-1:0] acc_nxt_c [N];

    // Handshake and load-termination decode
    assign beat_c       = p_vld & u_vld & rdy_q & (state_q == ST_LOAD);
    assign last_any_c   = p_last | u_last;
    assign load_end_c   = beat_c & ((j_q == LAST_IDX) | last_any_c);
    assign proto_err_c  = (last_any_c & (j_q != LAST_IDX)) |
                          (~last_any_c & (j_q == LAST_IDX)) |
                          (p_last ^ u_last);
    assign drain_adv_c  = ~z_vld_q | z_rdy;
    assign drain_done_c = z_vld_q & z_last_q & z_rdy;

    // Signed u to residue: negative values wrap to u+Q
    assign u_sx_c  = {{(QW + 1 - UW){u_data[UW-1]}}, u_data};
    assign u_res_c = u_data[UW-1] ? QW'(u_sx_c + Q_E) : QW'(u_sx_c);

    // One schoolbook column per cycle: acc_i +-= p_k * u_(i-k), wrap term negated in negacyclic mode
    always_comb begin
        for (int i = 0; i < N; i++) begin
            u_idx_c[i]   = IW'(i) - k_q;
            prod_c[i]    = PW'(p_mem[k_q]) * PW'(u_mem[u_idx_c[i]]);
            red_c[i]     = QW'(prod_c[i] % Q_P);
            tmp_c[i]     = '0;
            acc_nxt_c[i] = acc[i];
            if (mode_q && (IW'(i) < k_q)) begin
                tmp_c[i] = {1'b0, acc[i]} - {1'b0, red_c[i]};
                if (acc[i] < red_c[i]) begin
                    acc_nxt_c[i] = QW'(tmp_c[i] + Q_E);
                end else begin
                    acc_nxt_c[i] = QW'(tmp_c[i]);
                end
            end else begin
                tmp_c[i] = {1'b0, acc[i]} + {1'b0, red_c[i]};
                if (tmp_c[i] >= Q_E) begin
                    acc_nxt_c[i] = QW'(tmp_c[i] - Q_E);
                end else begin
                    acc_nxt_c[i] = QW'(tmp_c[i]);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (load_end_c) state_d = ST_COMPUTE;
            ST_COMPUTE: if (k_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_done_c) state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            j_q      <= '0;
            k_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            z_vld_q  <= 1'b0;
            z_last_q <= 1'b0;
            z_data_q <= '0;
            for (int i = 0; i < N; i++) begin
                p_mem[i] <= '0;
                u_mem[i] <= '0;
                acc[i]   <= '0;
            end
        end else begin
            rdy_q  <= (state_d == ST_LOAD);
            busy_q <= (state_d != ST_LOAD);
            err_q  <= beat_c & proto_err_c;
            case (state_q)
                ST_LOAD: begin
                    if (beat_c) begin
                        p_mem[j_q] <= p_data;
                        u_mem[j_q] <= u_res_c;
                        if (j_q == '0) mode_q <= mode_neg;
                        j_q <= j_q + IW'(1);
                        if (load_end_c) begin
                            j_q <= '0;
                            k_q <= '0;
                            for (int i = 0; i < N; i++) acc[i] <= '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    for (int i = 0; i < N; i++) acc[i] <= acc_nxt_c[i];
                    k_q <= k_q + IW'(1);
                end
                ST_DRAIN: begin
                    if (drain_done_c) begin
                        // Clearing storage makes coefficients missing after an early last read as 0
                        z_vld_q  <= 1'b0;
                        z_last_q <= 1'b0;
                        d_q      <= '0;
                        for (int i = 0; i < N; i++) begin
                            p_mem[i] <= '0;
                            u_mem[i] <= '0;
                        end
                    end else if (drain_adv_c) begin
                        z_vld_q  <= 1'b1;
                        z_data_q <= acc[d_q];
                        z_last_q <= (d_q == LAST_IDX);
                        d_q      <= d_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign p_rdy  = rdy_q;
    assign u_rdy  = rdy_q;
    assign z_vld  = z_vld_q;
    assign z_data = z_data_q;
    assign z_last = z_last_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_negacyclic_polymul.sv
// Scoreboard bench for negacyclic_polymul at N=4, Q=17.
module tb_negacyclic_polymul;

    localparam int unsigned N  = 4;
    localparam int unsigned QW = 5;
    localparam int unsigned Q  = 17;
    localparam int unsigned UW = 2;

    logic          clk = 1'b0;
    logic          a_rst_n = 1'b0;
    logic          p_vld = 1'b0, u_vld = 1'b0, p_last = 1'b0, u_last = 1'b0;
    logic [QW-1:0] p_data = '0;
    logic [UW-1:0] u_data = '0;
    logic          mode_neg = 1'b0;
    logic          z_rdy = 1'b1;
    logic          p_rdy, u_rdy, z_vld, z_last, err, busy;
    logic [QW-1:0] z_data;

    negacyclic_polymul #(.N(N), .QW(QW), .Q(Q), .UW(UW)) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .p_vld(p_vld), .p_rdy(p_rdy), .p_data(p_data), .p_last(p_last),
        .u_vld(u_vld), .u_rdy(u_rdy), .u_data(u_data), .u_last(u_last),
        .mode_neg(mode_neg),
        .z_vld(z_vld), .z_rdy(z_rdy), .z_data(z_data), .z_last(z_last),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_q[$];
    int expl_q[$];
    int beats = 0;
    int err_cnt = 0;
    bit stalled = 0;
    int s_data = 0;
    int s_last = 0;
    bit rdy_chk = 0;
    int first_vld_cyc = -1;
    int last_cyc = -1;
    int mon_e, mon_l;

    // Output monitor: scoreboard compare, stall stability, readiness around drain
    always @(negedge clk) begin
        if (a_rst_n) begin
            if (err) err_cnt++;
            if (rdy_chk) begin
                check("rdy_after_last", int'(p_rdy), 1);
                rdy_chk = 0;
            end
            if (stalled) begin
                check("stall_vld", int'(z_vld), 1);
                check("stall_data", int'(z_data), s_data);
                check("stall_last", int'(z_last), s_last);
            end
            if (z_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                check("rdy_low_drain", int'(p_rdy), 0);
            end
            stalled = z_vld && !z_rdy;
            s_data  = int'(z_data);
            s_last  = int'(z_last);
            if (z_vld && z_rdy) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", int'(z_vld), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = expl_q.pop_front();
                    check("z_data", int'(z_data), mon_e);
                    check("z_last", int'(z_last), mon_l);
                end
                if (z_last) begin
                    rdy_chk  = 1;
                    last_cyc = cyc;
                end
            end
        end else begin
            stalled = 0;
            rdy_chk = 0;
        end
    end

    int tp[N];
    int tu[N];
    int t_last = 0;

    // Push the expected result, then drive len beats; mode_neg flips after beat 0
    task automatic send(input int len, input bit neg, input bit p_only);
        int z[N];
        int n;
        for (int i = 0; i < N; i++) z[i] = 0;
        for (int j = 0; j < len; j++)
            for (int k = 0; k < len; k++)
                if (neg && (j + k >= N)) z[(j + k) % N] -= tp[j] * tu[k];
                else                     z[(j + k) % N] += tp[j] * tu[k];
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(((z[i] % int'(Q)) + int'(Q)) % int'(Q));
            expl_q.push_back((i == N - 1) ? 1 : 0);
        end
        for (int j = 0; j < len; j++) begin
            p_data   = QW'(tp[j]);
            u_data   = UW'(tu[j]);
            p_vld    = 1'b1;
            u_vld    = 1'b1;
            p_last   = (j == len - 1);
            u_last   = (j == len - 1) && !p_only;
            mode_neg = (j == 0) ? neg : !neg;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!p_rdy && n < 200);
            if (!p_rdy) check("p_rdy_timeout", int'(p_rdy), 1);
            @(posedge clk);
            #1;
        end
        t_last = cyc;
        p_vld  = 1'b0;
        u_vld  = 1'b0;
        p_last = 1'b0;
        u_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_poly(input int p0, input int p1, input int p2, input int p3,
                            input int u0, input int u1, input int u2, input int u3);
        tp[0] = p0; tp[1] = p1; tp[2] = p2; tp[3] = p3;
        tu[0] = u0; tu[1] = u1; tu[2] = u2; tu[3] = u3;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_rdy"}, int'(p_rdy), 0);
        check({tag, "_u_rdy"}, int'(u_rdy), 0);
        check({tag, "_z_vld"}, int'(z_vld), 0);
        check({tag, "_z_last"}, int'(z_last), 0);
        check({tag, "_z_data"}, int'(z_data), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int base_err, base_beats, n;

    initial begin
        #2;
        check_reset_outputs("reset");
        #10;
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_reset_p", int'(p_rdy), 1);
        check("rdy_after_reset_u", int'(u_rdy), 1);

        // Identity multiplier, with latency measurement
        base_err = err_cnt;
        first_vld_cyc = -1;
        set_poly(1, 2, 3, 4, 1, 0, 0, 0);
        send(N, 1'b1, 1'b0);
        wait_drain();
        check("latency_first_vld", first_vld_cyc - t_last, N + 1);
        check("latency_last", last_cyc - t_last, 2 * N);

        // Shift by x, negacyclic then cyclic
        set_poly(1, 2, 3, 4, 0, 1, 0, 0);
        send(N, 1'b1, 1'b0);
        wait_drain();
        send(N, 1'b0, 1'b0);
        wait_drain();

        // Signed u ingest
        set_poly(1, 2, 3, 4, -1, 0, 0, 0);
        send(N, 1'b1, 1'b0);
        wait_drain();

        // Worst-case reduction
        set_poly(16, 16, 16, 16, 1, 1, 1, 1);
        send(N, 1'b1, 1'b0);
        wait_drain();
        check("no_err_normal", err_cnt - base_err, 0);

        // Backpressure pattern during drain
        set_poly(3, 7, 11, 15, 1, -2, 0, 1);
        z_rdy = 1'b0;
        base_beats = beats;
        send(N, 1'b1, 1'b0);
        n = 0;
        while (!z_vld && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_first_vld", int'(z_vld), 1);
        for (int i = 0; i < 7; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            z_rdy = pat[i][0];
        end
        @(posedge clk);
        #1;
        z_rdy = 1'b1;
        check("stall_beats", beats - base_beats, N);
        check("stall_vld_after", int'(z_vld), 0);
        wait_drain();

        // Early last on j=1
        base_err = err_cnt;
        set_poly(5, 6, 0, 0, 1, 0, 0, 0);
        send(2, 1'b1, 1'b0);
        wait_drain();
        check("err_early_last", err_cnt - base_err, 1);

        // Mismatched last on the final beat
        base_err = err_cnt;
        set_poly(9, 1, 4, 13, 1, 1, -1, 0);
        send(N, 1'b1, 1'b1);
        wait_drain();
        check("err_mismatch_last", err_cnt - base_err, 1);

        // Random polynomials in both modes
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < N; j++) begin
                tp[j] = int'($urandom_range(0, Q - 1));
                tu[j] = int'($urandom_range(0, 3)) - 2;
            end
            send(N, 1'(r % 2), 1'b0);
            wait_drain();
        end

        // Reset during compute
        set_poly(2, 4, 6, 8, 1, 1, 0, 0);
        send(N, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("busy_compute", int'(busy), 1);
        a_rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        expl_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_mid_reset", int'(p_rdy), 1);
        set_poly(1, 2, 3, 4, 0, 0, 1, 0);
        send(N, 1'b1, 1'b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end

endmodule
